// File: rtl/spi_reg_pkg.sv
// Shared definitions for the raybox-zero register SPI receiver: command codes,
// payload lengths, reset values and the frame FSM state encoding.
package spi_reg_pkg;

  localparam int CMD_W         = 4;
  localparam int MAX_PAYLOAD_W = 16;
  localparam int CNT_W         = 5;

  localparam logic [CMD_W-1:0] CMD_SKY   = 4'd0;
  localparam logic [CMD_W-1:0] CMD_FLOOR = 4'd1;
  localparam logic [CMD_W-1:0] CMD_LEAK  = 4'd2;
  localparam logic [CMD_W-1:0] CMD_MAPD  = 4'd3;

  localparam logic [5:0]               SKY_RST   = 6'h17;
  localparam logic [5:0]               FLOOR_RST = 6'h15;
  localparam logic [5:0]               LEAK_RST  = 6'h00;
  localparam logic [MAX_PAYLOAD_W-1:0] MAPD_RST  = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE,
    ST_IGNORE
  } state_t;

  // Zero length marks an unknown command.
  function automatic logic [CNT_W-1:0] payload_len(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_SKY, CMD_FLOOR, CMD_LEAK: return 5'd6;
      CMD_MAPD:                     return 5'd16;
      default:                      return 5'd0;
    endcase
  endfunction

  function automatic logic [5:0] small_rst(input int idx);
    case (idx)
      0:       return SKY_RST;
      1:       return FLOOR_RST;
      default: return LEAK_RST;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser for the {csb, sclk, mosi} pins with an sclk rising-edge pulse.
// SYNC_STAGES must be at least 2.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] pins,
  output logic       csb,
  output logic       mosi,
  output logic       sclk_rise
);

  logic [2:0] last;
  logic       sclk_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [2:0] q;
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_reset) q <= 3'b000;
          else         q <= pins;
        end
      end else begin : g_next
        always_ff @(posedge i_clk) begin
          if (i_reset) q <= 3'b000;
          else         q <= g_stage[gi-1].q;
        end
      end
    end
  endgenerate

  assign last = g_stage[SYNC_STAGES-1].q;

  always_ff @(posedge i_clk) begin
    if (i_reset) sclk_d_reg <= 1'b0;
    else         sclk_d_reg <= last[1];
  end

  assign csb       = last[2];
  assign mosi      = last[0];
  assign sclk_rise = last[1] & ~sclk_d_reg;

endmodule

// File: rtl/spi_reg_rx.sv
// Register-load SPI receiver for raybox-zero render parameters.
// Define SPI_REG_DBL_BUF_EN to hold writes in shadows until i_frame_tick.
import spi_reg_pkg::*;

module spi_reg_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_reg_csb,
  input  logic        i_reg_sclk,
  input  logic        i_reg_mosi,
  input  logic        i_frame_tick,
  output logic [5:0]  o_sky,
  output logic [5:0]  o_floor,
  output logic [5:0]  o_leak,
  output logic [15:0] o_mapd,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic        o_pending
);

  logic csb_s, mosi_s, sclk_rise;
  logic csb_prev_reg, csb_rise, csb_fall;

  state_t                   state_reg;
  logic [CNT_W-1:0]         bit_cnt_reg, len_reg;
  logic [CMD_W-1:0]         cmd_reg, cmd_next;
  logic [MAX_PAYLOAD_W-1:0] shift_reg;
  logic                     overrun_reg, ok_reg, err_reg;
  logic                     stage_en;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .pins     ({i_reg_csb, i_reg_sclk, i_reg_mosi}),
    .csb      (csb_s),
    .mosi     (mosi_s),
    .sclk_rise(sclk_rise)
  );

  // csb_prev resets low so a frame already under way at reset release never looks like a fall.
  assign csb_rise = csb_s & ~csb_prev_reg;
  assign csb_fall = ~csb_s & csb_prev_reg;
  assign cmd_next = {shift_reg[CMD_W-2:0], mosi_s};
  assign stage_en = (state_reg == ST_DONE) && csb_rise && !overrun_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      csb_prev_reg <= 1'b0;
      bit_cnt_reg  <= '0;
      len_reg      <= '0;
      cmd_reg      <= '0;
      shift_reg    <= '0;
      overrun_reg  <= 1'b0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      csb_prev_reg <= csb_s;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (csb_fall) begin
            state_reg   <= ST_CMD;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            overrun_reg <= 1'b0;
          end
        end
        ST_CMD: begin
          if (csb_rise) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (sclk_rise) begin
            if (bit_cnt_reg == CNT_W'(CMD_W - 1)) begin
              cmd_reg     <= cmd_next;
              len_reg     <= payload_len(cmd_next);
              bit_cnt_reg <= '0;
              shift_reg   <= '0;
              state_reg   <= (payload_len(cmd_next) != '0) ? ST_DATA : ST_IGNORE;
            end else begin
              shift_reg   <= {shift_reg[MAX_PAYLOAD_W-2:0], mosi_s};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (csb_rise) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (sclk_rise) begin
            shift_reg   <= {shift_reg[MAX_PAYLOAD_W-2:0], mosi_s};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == len_reg - 1'b1) state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (csb_rise) begin
            ok_reg      <= !overrun_reg;
            err_reg     <= overrun_reg;
            overrun_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end else if (sclk_rise) begin
            overrun_reg <= 1'b1;
          end
        end
        ST_IGNORE: begin
          if (csb_rise) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_ok  = ok_reg;
  assign o_frame_err = err_reg;

  logic [5:0]  small_out [3];
  logic [15:0] mapd_out;

`ifdef SPI_REG_DBL_BUF_EN
  logic [3:0] pend_next_vec;
  logic       pending_reg;
`endif

  // Sky, floor and leak share width and differ only in command code and reset value.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_small
      logic [5:0] out_reg;
      logic       sel;
      assign sel = stage_en && (cmd_reg == CMD_W'(gi));
`ifdef SPI_REG_DBL_BUF_EN
      logic [5:0] shadow_reg;
      logic       pend_reg;
      assign pend_next_vec[gi] = sel ? 1'b1 : (i_frame_tick ? 1'b0 : pend_reg);
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          out_reg    <= small_rst(gi);
          shadow_reg <= small_rst(gi);
          pend_reg   <= 1'b0;
        end else begin
          if (sel) shadow_reg <= shift_reg[5:0];
          if (i_frame_tick && pend_reg) out_reg <= shadow_reg;
          pend_reg <= pend_next_vec[gi];
        end
      end
`else
      always_ff @(posedge i_clk) begin
        if (i_reset)  out_reg <= small_rst(gi);
        else if (sel) out_reg <= shift_reg[5:0];
      end
`endif
      assign small_out[gi] = out_reg;
    end
  endgenerate

  logic mapd_sel;
  assign mapd_sel = stage_en && (cmd_reg == CMD_MAPD);

`ifdef SPI_REG_DBL_BUF_EN
  logic [15:0] mapd_shadow_reg;
  logic        mapd_pend_reg;
  // A tick in the staging cycle commits the old shadow; the new write stays pending.
  assign pend_next_vec[3] = mapd_sel ? 1'b1 : (i_frame_tick ? 1'b0 : mapd_pend_reg);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mapd_out        <= MAPD_RST;
      mapd_shadow_reg <= MAPD_RST;
      mapd_pend_reg   <= 1'b0;
      pending_reg     <= 1'b0;
    end else begin
      if (mapd_sel) mapd_shadow_reg <= shift_reg;
      if (i_frame_tick && mapd_pend_reg) mapd_out <= mapd_shadow_reg;
      mapd_pend_reg <= pend_next_vec[3];
      pending_reg   <= |pend_next_vec;
    end
  end
  assign o_pending = pending_reg;
`else
  logic unused_tick;
  assign unused_tick = i_frame_tick;
  always_ff @(posedge i_clk) begin
    if (i_reset)       mapd_out <= MAPD_RST;
    else if (mapd_sel) mapd_out <= shift_reg;
  end
  assign o_pending = 1'b0;
`endif

  assign o_sky   = small_out[0];
  assign o_floor = small_out[1];
  assign o_leak  = small_out[2];
  assign o_mapd  = mapd_out;

endmodule

// File: tb/tb_spi_reg_rx.sv
// Scoreboard bench for spi_reg_rx: directed SPI frames push expected responses and
// register snapshots; monitors pop and compare when the DUT pulses or its outputs change.
module tb_spi_reg_rx;

  localparam int SS = 2;

  localparam logic [33:0] S_RST = {6'h17, 6'h15, 6'h00, 16'h0000};
  localparam logic [33:0] S1    = {6'h2A, 6'h15, 6'h00, 16'h0000};
  localparam logic [33:0] S2    = {6'h2A, 6'h15, 6'h00, 16'hA55A};
  localparam logic [33:0] S3    = {6'h2A, 6'h15, 6'h05, 16'hA55A};
  localparam logic [33:0] S4    = {6'h3C, 6'h15, 6'h05, 16'hA55A};
  localparam logic [33:0] S5    = {6'h01, 6'h15, 6'h00, 16'h0000};

  logic        clk = 1'b0;
  logic        reset, csb, sclk, mosi, frame_tick;
  logic [5:0]  o_sky, o_floor, o_leak;
  logic [15:0] o_mapd;
  logic        o_frame_ok, o_frame_err, o_pending;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  bit          resp_q [$];
  logic [33:0] snap_q [$];

  always #5 clk = ~clk;

  spi_reg_rx #(.SYNC_STAGES(SS)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_reg_csb   (csb),
    .i_reg_sclk  (sclk),
    .i_reg_mosi  (mosi),
    .i_frame_tick(frame_tick),
    .o_sky       (o_sky),
    .o_floor     (o_floor),
    .o_leak      (o_leak),
    .o_mapd      (o_mapd),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err),
    .o_pending   (o_pending)
  );

  function automatic logic [33:0] snap();
    return {o_sky, o_floor, o_leak, o_mapd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick_pulse();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Mode-0 SPI: mosi changes while sclk is low, 8 i_clk per bit. Optional tick lands
  // exactly in the cycle the csb rise is acted on.
  task automatic spi_bits(input logic [31:0] bits, input int n, input bit raise, input bit tick_same);
    @(posedge clk); #1 csb = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      #1 mosi = bits[i];
      repeat (4) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (4) @(posedge clk);
      #1 sclk = 1'b0;
    end
    repeat (4) @(posedge clk);
    if (raise) begin
      #1 csb = 1'b1;
      if (tick_same) begin
        repeat (SS) @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
      end
      repeat (8) @(posedge clk);
    end
    #1;
  endtask

  initial begin : resp_mon
    bit exp_ok;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (o_frame_ok || o_frame_err) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", {o_frame_ok, o_frame_err}, 2'b00);
        end else begin
          exp_ok = resp_q.pop_front();
          check("resp", {o_frame_ok, o_frame_err}, exp_ok ? 2'b10 : 2'b01);
          $display("resp: ok=%0b err=%0b expected_ok=%0b", o_frame_ok, o_frame_err, exp_ok);
        end
      end
    end
  end

  initial begin : snap_mon
    logic [33:0] last;
    wait (mon_en);
    last = snap();
    forever begin
      @(negedge clk);
      if (snap() !== last) begin
        if (snap_q.size() == 0) check("snap_unexpected", {30'd0, snap()}, {30'd0, last});
        else check("snap", {30'd0, snap()}, {30'd0, snap_q.pop_front()});
        $display("regs: sky=%h floor=%h leak=%h mapd=%h", o_sky, o_floor, o_leak, o_mapd);
        last = snap();
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; csb = 1'b1; sclk = 1'b0; mosi = 1'b0; frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", {30'd0, snap()}, {30'd0, S_RST});
    check("reset_flags", {o_frame_ok, o_frame_err, o_pending}, 3'b000);
    mon_en = 1'b1;

    // SKY 6'h2A
    resp_q.push_back(1'b1);
`ifdef SPI_REG_DBL_BUF_EN
    spi_bits(32'h02A, 10, 1'b1, 1'b0);
    check("sky_before_tick", o_sky, 6'h17);
    check("pending_sky", o_pending, 1'b1);
    snap_q.push_back(S1);
    tick_pulse();
    check("sky_after_tick", o_sky, 6'h2A);
    check("pending_clear", o_pending, 1'b0);
`else
    snap_q.push_back(S1);
    spi_bits(32'h02A, 10, 1'b1, 1'b0);
    check("sky_direct", o_sky, 6'h2A);
    check("pending_zero", o_pending, 1'b0);
`endif
    $display("txn: sky frame 2A done");

    // MAPD 16'hA55A
    resp_q.push_back(1'b1);
`ifdef SPI_REG_DBL_BUF_EN
    spi_bits(32'h3A55A, 20, 1'b1, 1'b0);
    check("mapd_before_tick", o_mapd, 16'h0000);
    check("pending_mapd", o_pending, 1'b1);
    snap_q.push_back(S2);
    tick_pulse();
`else
    snap_q.push_back(S2);
    spi_bits(32'h3A55A, 20, 1'b1, 1'b0);
`endif
    check("mapd", o_mapd, 16'hA55A);
    $display("txn: mapd frame A55A done");

    // LEAK aborted after 7 of 10 bits
    resp_q.push_back(1'b0);
    spi_bits(32'h15, 7, 1'b1, 1'b0);
    check("leak_abort", o_leak, 6'h00);
    check("pending_abort", o_pending, 1'b0);
    $display("txn: leak abort done");

    // unknown command 9 with 12 payload bits
    resp_q.push_back(1'b0);
    spi_bits(32'h9ABC, 16, 1'b1, 1'b0);
    check("unknown_regs", {30'd0, snap()}, {30'd0, S2});
    $display("txn: unknown cmd done");

    // FLOOR with two extra bits
    resp_q.push_back(1'b0);
    spi_bits(32'h1CF, 12, 1'b1, 1'b0);
    tick_pulse();
    check("floor_overrun", o_floor, 6'h15);
    check("pending_overrun", o_pending, 1'b0);
    $display("txn: floor overrun done");

    // LEAK 05 staged, then SKY 3C staged in the same cycle as a tick
    resp_q.push_back(1'b1);
    resp_q.push_back(1'b1);
    snap_q.push_back(S3);
    snap_q.push_back(S4);
`ifdef SPI_REG_DBL_BUF_EN
    spi_bits(32'h085, 10, 1'b1, 1'b0);
    check("leak_staged", o_leak, 6'h00);
    spi_bits(32'h03C, 10, 1'b1, 1'b1);
    check("sky_same_tick", o_sky, 6'h2A);
    check("leak_same_tick", o_leak, 6'h05);
    check("pending_same_tick", o_pending, 1'b1);
    tick_pulse();
    check("sky_next_tick", o_sky, 6'h3C);
    check("pending_next_tick", o_pending, 1'b0);
`else
    spi_bits(32'h085, 10, 1'b1, 1'b0);
    check("leak_direct", o_leak, 6'h05);
    spi_bits(32'h03C, 10, 1'b1, 1'b1);
    check("sky_tick_ignored", o_sky, 6'h3C);
`endif
    $display("txn: same-cycle tick done");

    // reset in the middle of a frame; the tail of that frame must be ignored
    spi_bits(32'h1F, 5, 1'b0, 1'b0);
    snap_q.push_back(S_RST);
    do_reset();
    spi_bits(32'h5, 3, 1'b1, 1'b0);
    check("midreset_regs", {30'd0, snap()}, {30'd0, S_RST});
    check("midreset_pending", o_pending, 1'b0);
    $display("txn: mid-frame reset done");

    // a clean frame after reset is accepted
    resp_q.push_back(1'b1);
`ifdef SPI_REG_DBL_BUF_EN
    spi_bits(32'h001, 10, 1'b1, 1'b0);
    snap_q.push_back(S5);
    tick_pulse();
`else
    snap_q.push_back(S5);
    spi_bits(32'h001, 10, 1'b1, 1'b0);
`endif
    check("sky_after_reset", o_sky, 6'h01);
    $display("txn: sky frame 01 after reset done");

    repeat (20) @(posedge clk);
    #1;
    check("resp_queue_empty", resp_q.size(), 0);
    check("snap_queue_empty", snap_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
